hsv2rgb_pipe: RTL and testbench

HSV2RGB_PIPE -- requirements
Module: hsv2rgb_pipe

---
 rtl/hsv_pkg.sv | 40 ++++
 rtl/hsv2rgb_pipe_if.sv | 31 +++
 rtl/hsv_sector.sv | 26 ++
 rtl/hsv2rgb_pipe.sv | 116 +++++++++++
 tb/tb_hsv2rgb_pipe.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/hsv_pkg.sv
// Shared constants, timing payload type and the divide-by-K helper for the
// HSV-to-RGB pipeline.
//   CH_W / H_W / H_MAX      : channel width, hue width, largest legal hue
//   SECTOR_W / SECTOR_DEG   : hue sector index width and degrees per sector
//   K, RECIP, RECIP_SHIFT   : 255*60 and its reciprocal multiply/shift pair
//   LATENCY                 : fixed pipeline depth in cycles
package hsv_pkg;

    localparam int unsigned CH_W        = 8;
    localparam int unsigned H_W         = 9;
    localparam int unsigned H_MAX       = 359;
    localparam int unsigned SECTOR_W    = 3;
    localparam int unsigned SECTOR_DEG  = 60;
    localparam int unsigned NUM_SECTORS = 6;
    localparam int unsigned F_W         = 6;
    localparam int unsigned K           = 15300;
    localparam int unsigned K_W         = 14;
    localparam int unsigned NUM_W       = 22;
    // ceil(2^36 / 15300); error term 14264 * 3901500 < 2^36, so the
    // multiply-and-shift equals floor(num / K) for every numerator <= 255*K.
    localparam int unsigned RECIP       = 4491470;
    localparam int unsigned RECIP_W     = 23;
    localparam int unsigned RECIP_SHIFT = 36;
    localparam int unsigned PROD_W      = NUM_W + RECIP_W;
    localparam int unsigned LATENCY     = 4;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } timing_t;

    // floor(num / K) via reciprocal multiply and shift
    function automatic logic [CH_W-1:0] div_k(input logic [NUM_W-1:0] num);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(num) * PROD_W'(RECIP);
        return CH_W'(prod >> RECIP_SHIFT);
    endfunction

endpackage

// File: rtl/hsv2rgb_pipe_if.sv
// Pixel bus for the HSV-to-RGB pipeline.
//   in_*  : HSV pixel, valid and video timing bits (master -> slave)
//   out_* : RGB pixel, valid and delayed timing bits (slave -> master)
interface hsv2rgb_pipe_if #(
    parameter int unsigned CH_W = hsv_pkg::CH_W
);
    logic                    in_valid;
    logic [hsv_pkg::H_W-1:0] in_h;
    logic [CH_W-1:0]         in_s;
    logic [CH_W-1:0]         in_v;
    logic                    in_de;
    logic                    in_hsync;
    logic                    in_vsync;
    logic                    out_valid;
    logic [CH_W-1:0]         out_r;
    logic [CH_W-1:0]         out_g;
    logic [CH_W-1:0]         out_b;
    logic                    out_de;
    logic                    out_hsync;
    logic                    out_vsync;

    modport master (
        output in_valid, in_h, in_s, in_v, in_de, in_hsync, in_vsync,
        input  out_valid, out_r, out_g, out_b, out_de, out_hsync, out_vsync
    );

    modport slave (
        input  in_valid, in_h, in_s, in_v, in_de, in_hsync, in_vsync,
        output out_valid, out_r, out_g, out_b, out_de, out_hsync, out_vsync
    );
endinterface

// File: rtl/hsv_sector.sv
// Combinational hue split: sector = floor(h/60), f = h mod 60.
//   h      : hue, already saturated to the legal range
//   sector : 0..5
//   f      : 0..59
module hsv_sector
    import hsv_pkg::*;
(
    input  logic [H_W-1:0]      h,
    output logic [SECTOR_W-1:0] sector,
    output logic [F_W-1:0]      f
);
    logic [H_W-1:0] base;

    // compare against each sector start instead of dividing
    always_comb begin
        sector = '0;
        base   = '0;
        for (int unsigned i = 1; i < NUM_SECTORS; i++) begin
            if (h >= H_W'(i * SECTOR_DEG)) begin
                sector = SECTOR_W'(i);
                base   = H_W'(i * SECTOR_DEG);
            end
        end
        f = F_W'(h - base);
    end
endmodule

// File: rtl/hsv2rgb_pipe.sv
// Four-stage HSV-to-RGB converter, one pixel per cycle, no backpressure.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of hsv2rgb_pipe_if (HSV in, RGB out, timing bits)
// Stage 1 saturates hue and splits it; stage 2 forms the p/q/t numerators;
// stage 3 divides by K; stage 4 selects channels by sector.
module hsv2rgb_pipe #(
    parameter int unsigned CH_W  = hsv_pkg::CH_W,
    parameter int unsigned H_MAX = hsv_pkg::H_MAX
) (
    input logic          clk,
    input logic          rst,
    hsv2rgb_pipe_if.slave bus
);
    import hsv_pkg::*;

    logic [LATENCY-1:0]  vld_q;
    timing_t             tim_q [LATENCY];

    logic [H_W-1:0]      h_sat_c;
    logic [SECTOR_W-1:0] sec_c;
    logic [F_W-1:0]      f_c;

    logic [SECTOR_W-1:0] sec1_q, sec2_q, sec3_q;
    logic [F_W-1:0]      f1_q;
    logic [CH_W-1:0]     s1_q, v1_q, v2_q, v3_q;
    logic [K_W-1:0]      s_k_c, f_k_c;
    logic [NUM_W-1:0]    np_c, nq_c, nt_c;
    logic [NUM_W-1:0]    np2_q, nq2_q, nt2_q;
    logic [CH_W-1:0]     p3_q, q3_q, t3_q;
    logic [CH_W-1:0]     r_c, g_c, b_c;
    logic [CH_W-1:0]     r4_q, g4_q, b4_q;

    // stage 1: hue saturation and sector split
    always_comb begin
        h_sat_c = (bus.in_h > H_W'(H_MAX)) ? H_W'(H_MAX) : bus.in_h;
    end

    hsv_sector u_sector (
        .h      (h_sat_c),
        .sector (sec_c),
        .f      (f_c)
    );

    // stage 2: numerators V*(K - S*x), at most 255*15300 so 22 bits suffice
    always_comb begin
        s_k_c = K_W'(s1_q);
        f_k_c = K_W'(f1_q);
        np_c  = NUM_W'(v1_q) * NUM_W'(K_W'(K) - s_k_c * K_W'(SECTOR_DEG));
        nq_c  = NUM_W'(v1_q) * NUM_W'(K_W'(K) - s_k_c * f_k_c);
        nt_c  = NUM_W'(v1_q) * NUM_W'(K_W'(K) - s_k_c * (K_W'(SECTOR_DEG) - f_k_c));
    end

    // stage 4: channel selection by sector
    always_comb begin
        r_c = v3_q;
        g_c = v3_q;
        b_c = v3_q;
        case (sec3_q)
            SECTOR_W'(0): begin r_c = v3_q; g_c = t3_q; b_c = p3_q; end
            SECTOR_W'(1): begin r_c = q3_q; g_c = v3_q; b_c = p3_q; end
            SECTOR_W'(2): begin r_c = p3_q; g_c = v3_q; b_c = t3_q; end
            SECTOR_W'(3): begin r_c = p3_q; g_c = q3_q; b_c = v3_q; end
            SECTOR_W'(4): begin r_c = t3_q; g_c = p3_q; b_c = v3_q; end
            SECTOR_W'(5): begin r_c = v3_q; g_c = p3_q; b_c = q3_q; end
            default: ;
        endcase
    end

    // valid and timing delay line; runs regardless of in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) tim_q[i] <= '0;
        end else begin
            vld_q    <= {vld_q[LATENCY-2:0], bus.in_valid};
            tim_q[0] <= {bus.in_de, bus.in_hsync, bus.in_vsync};
            for (int i = 1; i < LATENCY; i++) tim_q[i] <= tim_q[i-1];
        end
    end

    // data pipeline; invalid pixels still propagate
    always_ff @(posedge clk) begin
        if (rst) begin
            sec1_q <= '0; f1_q  <= '0; s1_q  <= '0; v1_q  <= '0;
            sec2_q <= '0; v2_q  <= '0; np2_q <= '0; nq2_q <= '0; nt2_q <= '0;
            sec3_q <= '0; v3_q  <= '0; p3_q  <= '0; q3_q  <= '0; t3_q  <= '0;
            r4_q   <= '0; g4_q  <= '0; b4_q  <= '0;
        end else begin
            sec1_q <= sec_c;
            f1_q   <= f_c;
            s1_q   <= bus.in_s;
            v1_q   <= bus.in_v;
            sec2_q <= sec1_q;
            v2_q   <= v1_q;
            np2_q  <= np_c;
            nq2_q  <= nq_c;
            nt2_q  <= nt_c;
            sec3_q <= sec2_q;
            v3_q   <= v2_q;
            p3_q   <= div_k(np2_q);
            q3_q   <= div_k(nq2_q);
            t3_q   <= div_k(nt2_q);
            r4_q   <= r_c;
            g4_q   <= g_c;
            b4_q   <= b_c;
        end
    end

    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.out_de    = tim_q[LATENCY-1].de;
    assign bus.out_hsync = tim_q[LATENCY-1].hsync;
    assign bus.out_vsync = tim_q[LATENCY-1].vsync;
    assign bus.out_r     = r4_q;
    assign bus.out_g     = g4_q;
    assign bus.out_b     = b4_q;
endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Self-checking bench for hsv2rgb_pipe: directed vector table, random
// streams against an integer floor-arithmetic model, hue sweep and
// reset-while-busy sequence. Expected outputs trail inputs by 4 cycles.
module tb_hsv2rgb_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hsv2rgb_pipe_if #(.CH_W(8)) bus ();

    hsv2rgb_pipe #(.CH_W(8), .H_MAX(359)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int h, s, v;
        int r, g, b;
    } vec_t;

    typedef struct {
        string      tag;
        logic       vld;
        logic       de, hs, vs;
        logic [7:0] r, g, b;
        bit         chk_rgb;
        bit         chk_max;
    } exp_t;

    vec_t vecs[9];
    exp_t pipe_q[$];

    // reference: HSV to RGB straight from the floor definitions
    function automatic void ref_rgb(input int h, input int s, input int v,
                                    output int r, output int g, output int b);
        int hh, sec, f, p, q, t;
        hh  = (h > 359) ? 359 : h;
        sec = hh / 60;
        f   = hh % 60;
        p   = (v * (15300 - s * 60)) / 15300;
        q   = (v * (15300 - s * f)) / 15300;
        t   = (v * (15300 - s * (60 - f))) / 15300;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
    endfunction

    // drive one cycle, advance the clock, compare the output that is due now
    task automatic step(input string tag, input bit r_in, input bit vld,
                        input int h, input int s, input int v,
                        input bit de, input bit hs, input bit vs,
                        input int er, input int eg, input int eb, input bit chk_max);
        exp_t e;
        int   mx, mn;
        rst          = r_in;
        bus.in_valid = vld;
        bus.in_h     = 9'(h);
        bus.in_s     = 8'(s);
        bus.in_v     = 8'(v);
        bus.in_de    = de;
        bus.in_hsync = hs;
        bus.in_vsync = vs;
        @(posedge clk);
        #1;
        if (r_in) begin
            e.tag = {tag, "_flush"};
            e.vld = 1'b0; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
            e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
            e.chk_rgb = 1'b1; e.chk_max = 1'b0;
            pipe_q.delete();
            repeat (4) pipe_q.push_back(e);
        end else begin
            e.tag = tag;
            e.vld = vld; e.de = de; e.hs = hs; e.vs = vs;
            e.r = 8'(er); e.g = 8'(eg); e.b = 8'(eb);
            e.chk_rgb = vld; e.chk_max = chk_max & vld;
            pipe_q.push_back(e);
        end
        e = pipe_q.pop_front();
        checks++;
        if (bus.out_valid !== e.vld || bus.out_de !== e.de || bus.out_hsync !== e.hs ||
            bus.out_vsync !== e.vs ||
            (e.chk_rgb && (bus.out_r !== e.r || bus.out_g !== e.g || bus.out_b !== e.b))) begin
            errors++;
            $display("FAIL %s: got valid=%0b tim=%0b%0b%0b rgb=(%0d,%0d,%0d) expected valid=%0b tim=%0b%0b%0b rgb=(%0d,%0d,%0d) rgb_checked=%0b",
                     e.tag, bus.out_valid, bus.out_de, bus.out_hsync, bus.out_vsync,
                     bus.out_r, bus.out_g, bus.out_b, e.vld, e.de, e.hs, e.vs,
                     e.r, e.g, e.b, e.chk_rgb);
        end
        if (e.chk_max) begin
            mx = int'(bus.out_r); mn = int'(bus.out_r);
            if (int'(bus.out_g) > mx) mx = int'(bus.out_g);
            if (int'(bus.out_b) > mx) mx = int'(bus.out_b);
            if (int'(bus.out_g) < mn) mn = int'(bus.out_g);
            if (int'(bus.out_b) < mn) mn = int'(bus.out_b);
            checks++;
            if (mx != 255 || mn != 0) begin
                errors++;
                $display("FAIL sweep_range: got max=%0d min=%0d expected max=255 min=0", mx, mn);
            end
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic rand_pixel(input string tag, input bit vld, input bit chk_max,
                              input int h, input int s, input int v);
        int r, g, b;
        ref_rgb(h, s, v, r, g, b);
        step(tag, 1'b0, vld, h, s, v, 1'(int'($urandom_range(0, 1))),
             1'(int'($urandom_range(0, 1))), 1'(int'($urandom_range(0, 1))),
             r, g, b, chk_max);
    endtask

    initial begin
        vecs[0] = '{h:0,   s:255, v:255, r:255, g:0,   b:0};
        vecs[1] = '{h:120, s:255, v:255, r:0,   g:255, b:0};
        vecs[2] = '{h:240, s:255, v:255, r:0,   g:0,   b:255};
        vecs[3] = '{h:60,  s:255, v:255, r:255, g:255, b:0};
        vecs[4] = '{h:30,  s:255, v:255, r:255, g:127, b:0};
        vecs[5] = '{h:200, s:0,   v:200, r:200, g:200, b:200};
        vecs[6] = '{h:400, s:255, v:255, r:255, g:0,   b:4};
        vecs[7] = '{h:180, s:255, v:255, r:0,   g:255, b:255};
        vecs[8] = '{h:100, s:128, v:200, r:133, g:200, b:99};

        // reset state
        step("reset", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        step("reset", 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) idle("idle");

        // directed vectors, each isolated so out_valid timing is exact
        foreach (vecs[i]) begin
            step($sformatf("vec%0d_h%0d", i, vecs[i].h), 1'b0, 1'b1,
                 vecs[i].h, vecs[i].s, vecs[i].v, 1'b1, 1'b0, 1'b1,
                 vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
            repeat (4) idle("gap");
        end

        // back-to-back random stream
        for (int i = 0; i < 1000; i++)
            rand_pixel("stream", 1'b1, 1'b0, int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        repeat (4) idle("drain");

        // random valid gaps with timing bits still moving
        for (int i = 0; i < 300; i++)
            rand_pixel("gappy", 1'(int'($urandom_range(0, 1))), 1'b0,
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)));
        repeat (4) idle("drain");

        // full hue sweep at S=V=255, covers every sector boundary
        for (int h = 0; h < 360; h++)
            rand_pixel($sformatf("sweep_h%0d", h), 1'b1, 1'b1, h, 255, 255);
        repeat (4) idle("drain");

        // reset with three pixels in flight, then a pixel right after reset
        for (int i = 0; i < 3; i++)
            rand_pixel("inflight", 1'b1, 1'b0, int'($urandom_range(0, 359)), 255, 255);
        step("rst_pulse", 1'b1, 1'b1, 0, 255, 255, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        step("post_reset", 1'b0, 1'b1, 30, 255, 255, 1'b1, 1'b0, 1'b0, 255, 127, 0, 1'b0);
        repeat (6) idle("tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
